// File: rtl/mac_seq_pkg.sv
// Shared types and constants for the dot-product sequencer that feeds the MAC.
package mac_seq_pkg;

  localparam int DATA_W      = 16;
  localparam int OUT_SEL_MAX = 24;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DRAIN  = 2'd2,
    RESULT = 2'd3
  } state_e;

endpackage

// File: rtl/mac_coef_bank.sv
// Coefficient register file: one 16-bit entry per product term, cleared on
// reset, written one entry per clock, read combinationally.
module mac_coef_bank
  import mac_seq_pkg::*;
#(
  parameter int COEF_DEPTH = 16,
  parameter int ADDR_W     = $clog2(COEF_DEPTH)
) (
  input  logic              MAC_ACC_CLK,
  input  logic              acc_ff_rstn,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  // Packed view of all entries so the read port is a plain indexed select.
  logic [COEF_DEPTH-1:0][DATA_W-1:0] bank_flat;

  genvar gi;
  generate
    for (gi = 0; gi < COEF_DEPTH; gi++) begin : g_entry
      logic [DATA_W-1:0] entry_q;
      logic [DATA_W-1:0] entry_d;

      // Load this entry only when it is the target of a permitted write.
      always_comb begin
        entry_d = entry_q;
        if (wr_en && (waddr == ADDR_W'(gi))) begin
          entry_d = wdata;
        end
      end

      // Entry storage; reset shares the MAC accumulator reset.
      always_ff @(posedge MAC_ACC_CLK or negedge acc_ff_rstn) begin
        if (!acc_ff_rstn) begin
          entry_q <= '0;
        end else begin
          entry_q <= entry_d;
        end
      end

      assign bank_flat[gi] = entry_q;
    end
  endgenerate

  assign rdata = bank_flat[raddr];

endmodule

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer: accepts a command, streams operands paired with
// stored coefficients into the MAC (clear/round-preload on the first term,
// accumulate after), waits one drain cycle, then presents the MAC result.
module mac_dot_seq
  import mac_seq_pkg::*;
#(
  parameter int COEF_DEPTH = 16,
  parameter int ADDR_W     = $clog2(COEF_DEPTH)
) (
  input  logic              MAC_ACC_CLK,
  input  logic              acc_ff_rstn,
  input  logic              coef_we,
  input  logic [ADDR_W-1:0] coef_waddr,
  input  logic [DATA_W-1:0] coef_wdata,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic [5:0]        cmd_out_sel,
  input  logic              cmd_rnd,
  input  logic              cmd_sat,
  input  logic              cmd_tc,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DATA_W-1:0] op_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              busy,
  output logic [DATA_W-1:0] MAC_OPER_DATA,
  output logic [DATA_W-1:0] MAC_COEF_DATA,
  output logic              EFPGA_MATHB_CLK_EN,
  output logic              MAC_ACC_CLEAR,
  output logic              MAC_ACC_RND,
  output logic              MAC_ACC_SAT,
  output logic [5:0]        MAC_OUT_SEL,
  output logic              MAC_TC,
  input  logic [DATA_W-1:0] MAC_OUT
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [5:0]          out_sel_q, out_sel_d;
  logic                rnd_q, rnd_d;
  logic                sat_q, sat_d;
  logic                tc_q, tc_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                first_q, first_d;
  logic                res_valid_q, res_valid_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic [DATA_W-1:0]   coef_rdata;

  logic cmd_accept;
  logic op_accept;
  logic res_accept;

  assign cmd_accept = cmd_valid && (state_q == IDLE);
  assign op_accept  = op_valid && (state_q == ACCUM);
  assign res_accept = res_valid_q && res_ready;

  // Coefficients may only change between operations.
  mac_coef_bank #(
    .COEF_DEPTH (COEF_DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_coef_bank (
    .MAC_ACC_CLK (MAC_ACC_CLK),
    .acc_ff_rstn (acc_ff_rstn),
    .wr_en       (coef_we && (state_q == IDLE)),
    .waddr       (coef_waddr),
    .wdata       (coef_wdata),
    .raddr       (idx_q),
    .rdata       (coef_rdata)
  );

  // State register.
  always_ff @(posedge MAC_ACC_CLK or negedge acc_ff_rstn) begin
    if (!acc_ff_rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: last operand accepted when idx reaches the latched length.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = ACCUM;
      ACCUM:   if (op_valid && (idx_q == len_q)) state_d = DRAIN;
      DRAIN:   state_d = RESULT;
      RESULT:  if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and MAC control outputs; MAC data inputs are zero outside ACCUM.
  always_comb begin
    cmd_ready          = (state_q == IDLE);
    busy               = (state_q != IDLE);
    op_ready           = 1'b0;
    EFPGA_MATHB_CLK_EN = 1'b0;
    MAC_ACC_CLEAR      = 1'b0;
    MAC_ACC_RND        = 1'b0;
    MAC_OPER_DATA      = '0;
    MAC_COEF_DATA      = '0;
    if (state_q == ACCUM) begin
      op_ready           = 1'b1;
      EFPGA_MATHB_CLK_EN = op_valid;
      MAC_ACC_CLEAR      = first_q && !rnd_q;
      MAC_ACC_RND        = first_q && rnd_q;
      MAC_OPER_DATA      = op_data;
      MAC_COEF_DATA      = coef_rdata;
    end
  end

  // Command latch, operand index, and result capture during the drain cycle.
  always_comb begin
    len_d       = len_q;
    out_sel_d   = out_sel_q;
    rnd_d       = rnd_q;
    sat_d       = sat_q;
    tc_d        = tc_q;
    idx_d       = idx_q;
    first_d     = first_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    if (cmd_accept) begin
      len_d     = cmd_len;
      out_sel_d = (cmd_out_sel > 6'(OUT_SEL_MAX)) ? 6'(OUT_SEL_MAX) : cmd_out_sel;
      rnd_d     = cmd_rnd;
      sat_d     = cmd_sat;
      tc_d      = cmd_tc;
      idx_d     = '0;
      first_d   = 1'b1;
    end
    if (op_accept) begin
      idx_d   = idx_q + ADDR_W'(1);
      first_d = 1'b0;
    end
    if (state_q == DRAIN) begin
      res_data_d  = MAC_OUT;
      res_valid_d = 1'b1;
    end
    if (res_accept) begin
      res_valid_d = 1'b0;
    end
  end

  // Datapath registers; reset discards any partial operation.
  always_ff @(posedge MAC_ACC_CLK or negedge acc_ff_rstn) begin
    if (!acc_ff_rstn) begin
      len_q       <= '0;
      out_sel_q   <= '0;
      rnd_q       <= 1'b0;
      sat_q       <= 1'b0;
      tc_q        <= 1'b0;
      idx_q       <= '0;
      first_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      len_q       <= len_d;
      out_sel_q   <= out_sel_d;
      rnd_q       <= rnd_d;
      sat_q       <= sat_d;
      tc_q        <= tc_d;
      idx_q       <= idx_d;
      first_q     <= first_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  // Mode bits stay on the latched values, including in IDLE, so the MAC
  // output select remains settled between operations.
  assign MAC_OUT_SEL = out_sel_q;
  assign MAC_ACC_SAT = sat_q;
  assign MAC_TC      = tc_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;

endmodule
